// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_txn_arbiter
//  Description : Shares the single I2C master engine of the IO-expander path
//                among NUM_REQ requesters (button poll, link-power readback,
//                port-status LED writes, optional host slow-word tunnel).
//                Each requester offers one CMD_W-bit command. The arbiter
//                grants round-robin, issues the granted command with a
//                valid/ready handshake, returns the engine response to the
//                granted requester, and aborts the engine on a timeout.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Build option:
//    I2C_ARB_PRIORITY0_EN  - when defined, requester 0 has strict priority
//                            over the round-robin group 1..NUM_REQ-1.
// ----------------------------------------------------------------------------
//  Ports:
//    i_clk           system clock (sys_clk)
//    i_reset_n       asynchronous active-low reset, synchronous release
//    i_req           per-requester request level
//    i_req_cmd       packed commands, requester k at [k*CMD_W +: CMD_W]
//                    command layout {rw, dev_addr[6:0], reg[7:0], wdata[7:0]}
//    o_gnt           one-hot grant, held from grant until response
//    o_rsp_valid     one-hot single-cycle response strobe
//    o_rsp_data      read data (0 on timeout)
//    o_rsp_nack      engine reported NACK
//    o_rsp_timeout   transaction timed out
//    o_cmd_valid     command to engine valid
//    o_cmd           latched granted command
//    i_cmd_ready     engine accepts command
//    i_rsp_valid     engine response strobe
//    i_rsp_data      engine read data
//    i_rsp_nack      engine NACK flag
//    o_engine_abort  single-cycle abort to engine
//    o_busy          arbiter is not idle
// ============================================================================
module i2c_txn_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = 60_000,
    parameter int CMD_W        = 24
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*CMD_W-1:0] i_req_cmd,
    output logic [NUM_REQ-1:0]       o_gnt,
    output logic [NUM_REQ-1:0]       o_rsp_valid,
    output logic [7:0]               o_rsp_data,
    output logic                     o_rsp_nack,
    output logic                     o_rsp_timeout,
    output logic                     o_cmd_valid,
    output logic [CMD_W-1:0]         o_cmd,
    input  logic                     i_cmd_ready,
    input  logic                     i_rsp_valid,
    input  logic [7:0]               i_rsp_data,
    input  logic                     i_rsp_nack,
    output logic                     o_engine_abort,
    output logic                     o_busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);

    // Last timer value before the timeout fires, and the saturation ceiling.
    localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT_CLKS - 1);
    localparam logic [TMR_W-1:0] c_tmr_max  = '1;
    // One extra bit so that rr_ptr + offset never overflows before the wrap.
    localparam logic [PTR_W:0]   c_num_req  = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] c_last_idx = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   gidx_q;
    logic [TMR_W-1:0]   timer_q;
    logic [TMR_W-1:0]   timer_d;

    logic [CMD_W-1:0]   w_cmd_arr [NUM_REQ];
    logic               w_sel_found;
    logic [PTR_W-1:0]   w_sel_idx;
    logic [NUM_REQ-1:0] w_sel_onehot;
    logic [PTR_W:0]     w_sum;
    logic [PTR_W-1:0]   w_cand;
    logic [PTR_W-1:0]   w_rr_next;

    // Split the packed command bus into one word per requester.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cmd_split
        assign w_cmd_arr[k] = i_req_cmd[k*CMD_W +: CMD_W];
    end

    // ------------------------------------------------------------------
    // Requester selection: first set request searching upward from
    // rr_ptr_q, wrapping modulo NUM_REQ.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sum       = '0;
        w_cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(i);
            if (w_sum >= c_num_req) begin
                w_sum = w_sum - c_num_req;
            end
            w_cand = w_sum[PTR_W-1:0];
            if (!w_sel_found && i_req[w_cand]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_cand;
            end
        end
`ifdef I2C_ARB_PRIORITY0_EN
        // Requester 0 overrides the rotating search entirely.
        if (i_req[0]) begin
            w_sel_found = 1'b1;
            w_sel_idx   = '0;
        end
`endif
    end

    assign w_sel_onehot = NUM_REQ'(1) << w_sel_idx;

    // Round-robin pointer after the current grant: one past the winner.
    assign w_rr_next = (gidx_q == c_last_idx) ? '0 : gidx_q + 1'b1;

    // Saturating timer: holds at all-ones rather than wrapping.
    always_comb begin
        timer_d = timer_q;
        if (timer_q != c_tmr_max) begin
            timer_d = timer_q + 1'b1;
        end
    end

    assign o_busy = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // Transaction FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            gidx_q         <= '0;
            timer_q        <= '0;
            o_gnt          <= '0;
            o_rsp_valid    <= '0;
            o_rsp_data     <= '0;
            o_rsp_nack     <= 1'b0;
            o_rsp_timeout  <= 1'b0;
            o_cmd_valid    <= 1'b0;
            o_cmd          <= '0;
            o_engine_abort <= 1'b0;
        end else begin
            // Strobes default low; they are raised for exactly one cycle.
            o_rsp_valid    <= '0;
            o_engine_abort <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (w_sel_found) begin
                        gidx_q      <= w_sel_idx;
                        o_gnt       <= w_sel_onehot;
                        o_cmd       <= w_cmd_arr[w_sel_idx];
                        o_cmd_valid <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // No timeout here: the engine is trusted to become ready.
                    if (i_cmd_ready) begin
                        o_cmd_valid <= 1'b0;
                        timer_q     <= '0;
                        state_q     <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    timer_q <= timer_d;
                    // A response arriving on the timeout cycle takes precedence.
                    if (i_rsp_valid) begin
                        o_rsp_valid   <= o_gnt;
                        o_rsp_data    <= i_rsp_data;
                        o_rsp_nack    <= i_rsp_nack;
                        o_rsp_timeout <= 1'b0;
                        state_q       <= ST_DONE;
                    end else if (timer_q >= c_tmr_last) begin
                        o_engine_abort <= 1'b1;
                        o_rsp_valid    <= o_gnt;
                        o_rsp_data     <= '0;
                        o_rsp_nack     <= 1'b0;
                        o_rsp_timeout  <= 1'b1;
                        state_q        <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    o_rsp_data    <= '0;
                    o_rsp_nack    <= 1'b0;
                    o_rsp_timeout <= 1'b0;
                    o_gnt         <= '0;
`ifdef I2C_ARB_PRIORITY0_EN
                    // Grants to requester 0 leave the rotation untouched so
                    // the order among 1..NUM_REQ-1 is preserved.
                    if (gidx_q != '0) begin
                        rr_ptr_q <= w_rr_next;
                    end
`else
                    rr_ptr_q <= w_rr_next;
`endif
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_txn_arbiter
//  Description : Scoreboard bench for i2c_txn_arbiter (NUM_REQ=4,
//                TIMEOUT_CLKS=16). Directed stimulus pushes expected grants
//                and responses; an independent monitor compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_txn_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 16;
    localparam int CW   = 24;

    typedef struct packed {
        logic [3:0] vec;
        logic [7:0] data;
        logic       nack;
        logic       tmo;
    } rsp_t;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*CW-1:0] req_cmd;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rspv;
    logic [7:0]        rsp_data;
    logic              rsp_nack;
    logic              rsp_tmo;
    logic              cmd_valid;
    logic [CW-1:0]     cmd;
    logic              cmd_ready;
    logic              eng_rsp_valid;
    logic [7:0]        eng_rsp_data;
    logic              eng_rsp_nack;
    logic              abort;
    logic              busy;

    int   tests;
    int   fails;
    int   aborts;
    int   gnt_q[$];
    rsp_t rsp_q[$];
    logic [CW-1:0] cmd_tab [NREQ];

    i2c_txn_arbiter #(
        .NUM_REQ      (NREQ),
        .TIMEOUT_CLKS (TMO),
        .CMD_W        (CW)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_req          (req),
        .i_req_cmd      (req_cmd),
        .o_gnt          (gnt),
        .o_rsp_valid    (rspv),
        .o_rsp_data     (rsp_data),
        .o_rsp_nack     (rsp_nack),
        .o_rsp_timeout  (rsp_tmo),
        .o_cmd_valid    (cmd_valid),
        .o_cmd          (cmd),
        .i_cmd_ready    (cmd_ready),
        .i_rsp_valid    (eng_rsp_valid),
        .i_rsp_data     (eng_rsp_data),
        .i_rsp_nack     (eng_rsp_nack),
        .o_engine_abort (abort),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rsp_t mk_rsp(input int idx, input logic [7:0] d, input logic n, input logic t);
        rsp_t r;
        r.vec  = 4'(1 << idx);
        r.data = d;
        r.nack = n;
        r.tmo  = t;
        return r;
    endfunction

    task automatic load_cmds();
        for (int k = 0; k < NREQ; k++) begin
            req_cmd[k*CW +: CW] = cmd_tab[k];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Engine model: wait for a command, accept it after rdy_wait cycles,
    // respond rsp_wait cycles after the handshake (negative: never respond).
    task automatic serve(input logic [CW-1:0] exp_cmd, input int rdy_wait, input int rsp_wait,
                         input logic [7:0] d, input logic n);
        int k;
        k = 0;
        while (cmd_valid !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        chk("issue_seen", 32'(cmd_valid), 32'(1));
        chk("issue_cmd", 32'(cmd), 32'(exp_cmd));
        repeat (rdy_wait) step();
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        if (rsp_wait >= 0) begin
            repeat (rsp_wait) step();
            eng_rsp_valid = 1'b1;
            eng_rsp_data  = d;
            eng_rsp_nack  = n;
            step();
            eng_rsp_valid = 1'b0;
            eng_rsp_data  = 8'h00;
            eng_rsp_nack  = 1'b0;
        end
    endtask

    task automatic txn(input int idx, input int rdy_wait, input int rsp_wait,
                       input logic [7:0] d, input logic n);
        gnt_q.push_back(idx);
        rsp_q.push_back(mk_rsp(idx, d, n, 1'b0));
        serve(cmd_tab[idx], rdy_wait, rsp_wait, d, n);
    endtask

    // Monitor: compares grants and responses against the scoreboard queues.
    initial begin
        logic [3:0] prev_gnt;
        logic       prev_rsp;
        int         e;
        rsp_t       r;
        prev_gnt = '0;
        prev_rsp = 1'b0;
        forever begin
            @(negedge clk);
            if (gnt != '0 && prev_gnt == '0) begin
                if (gnt_q.size() == 0) begin
                    chk("unexpected_grant", 32'(gnt), 32'(0));
                end else begin
                    e = gnt_q.pop_front();
                    chk("grant_order", 32'(gnt), 32'(1 << e));
                end
            end
            if (prev_rsp) begin
                chk("rsp_data_clear", 32'(rsp_data), 32'(0));
                chk("rsp_flags_clear", 32'({rsp_nack, rsp_tmo}), 32'(0));
            end
            if (rspv != '0) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rspv), 32'(0));
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_vec", 32'(rspv), 32'(r.vec));
                    chk("rsp_data", 32'(rsp_data), 32'(r.data));
                    chk("rsp_nack", 32'(rsp_nack), 32'(r.nack));
                    chk("rsp_timeout", 32'(rsp_tmo), 32'(r.tmo));
                    chk("gnt_held", 32'(gnt), 32'(r.vec));
                end
            end
            if (abort) aborts++;
            prev_gnt = gnt;
            prev_rsp = |rspv;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        tests         = 0;
        fails         = 0;
        aborts        = 0;
        rst_n         = 1'b0;
        req           = '0;
        req_cmd       = '0;
        cmd_ready     = 1'b0;
        eng_rsp_valid = 1'b0;
        eng_rsp_data  = 8'h00;
        eng_rsp_nack  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cmd_tab[k] = {1'b1, 7'(7'h20 + k), 8'(8'h10 + k), 8'h00};
        end
        load_cmds();

        // Reset state
        repeat (3) step();
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_rsp_valid", 32'(rspv), 32'(0));
        chk("rst_cmd_valid", 32'(cmd_valid), 32'(0));
        chk("rst_abort", 32'(abort), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_cmd", 32'(cmd), 32'(0));
        rst_n = 1'b1;
        step();

        // Fairness: all requesting, order 0,1,2,3,0
        req = 4'b1111;
        txn(0, 0, 0, 8'h11, 1'b0);
        txn(1, 1, 0, 8'h22, 1'b1);
        txn(2, 0, 2, 8'h33, 1'b0);
        txn(3, 0, 0, 8'h44, 1'b1);
        txn(0, 0, 0, 8'h55, 1'b0);
        req = '0;
        repeat (3) step();

        // Single request to requester 2 (rr_ptr now 1)
        cmd_tab[2] = 24'h9A1200;
        load_cmds();
        gnt_q.push_back(2);
        rsp_q.push_back(mk_rsp(2, 8'h5C, 1'b0, 1'b0));
        req = 4'b0100;
        step();
        chk("gnt_latency", 32'(gnt), 32'(4'b0100));
        chk("cmd_latched", 32'(cmd), 32'(24'h9A1200));
        chk("cmd_valid_issue", 32'(cmd_valid), 32'(1));
        req = '0;
        req_cmd[2*CW +: CW] = 24'hFFFFFF;
        eng_rsp_valid = 1'b1;
        eng_rsp_data  = 8'hEE;
        step();
        eng_rsp_valid = 1'b0;
        eng_rsp_data  = 8'h00;
        chk("cmd_stable", 32'(cmd), 32'(24'h9A1200));
        step();
        chk("cmd_valid_c3", 32'(cmd_valid), 32'(1));
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk("cmd_valid_drop", 32'(cmd_valid), 32'(0));
        chk("busy_wait", 32'(busy), 32'(1));
        repeat (9) step();
        eng_rsp_valid = 1'b1;
        eng_rsp_data  = 8'h5C;
        step();
        eng_rsp_valid = 1'b0;
        eng_rsp_data  = 8'h00;
        load_cmds();
        repeat (3) step();

        // Timeout on requester 1 (rr_ptr now 3, search 3,0,1)
        gnt_q.push_back(1);
        rsp_q.push_back(mk_rsp(1, 8'h00, 1'b0, 1'b1));
        req = 4'b0010;
        serve(cmd_tab[1], 0, -1, 8'h00, 1'b0);
        req = '0;
        for (int c = 1; c < TMO; c++) begin
            chk("abort_early", 32'(abort), 32'(0));
            step();
        end
        chk("abort_early", 32'(abort), 32'(0));
        step();
        chk("abort_pulse", 32'(abort), 32'(1));
        chk("timeout_flag", 32'(rsp_tmo), 32'(1));
        step();
        chk("abort_single", 32'(abort), 32'(0));
        repeat (3) step();

        // Response on the timeout cycle: response wins, no abort
        cmd_tab[3] = 24'h1B_40_00;
        load_cmds();
        req = 4'b1000;
        txn(3, 0, TMO - 1, 8'hA5, 1'b0);
        req = '0;
        chk("collide_no_abort", 32'(abort), 32'(0));
        chk("collide_rsp_vec", 32'(rspv), 32'(4'b1000));
        repeat (3) step();

        // Reset asserted mid-WAIT_RSP
        gnt_q.push_back(0);
        req = 4'b0001;
        serve(cmd_tab[0], 0, -1, 8'h00, 1'b0);
        req = '0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'(0));
        chk("arst_cmd_valid", 32'(cmd_valid), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        repeat (2) step();
        rst_n = 1'b1;
        eng_rsp_valid = 1'b1;
        eng_rsp_data  = 8'h77;
        step();
        eng_rsp_valid = 1'b0;
        eng_rsp_data  = 8'h00;
        repeat (20) step();
        chk("post_rst_busy", 32'(busy), 32'(0));

        // Priority case: rr_ptr = 1, then req[0] rises together with 1..3
        req = 4'b0001;
        txn(0, 0, 0, 8'h01, 1'b0);
        req = '0;
        repeat (3) step();
        req = 4'b1111;
`ifdef I2C_ARB_PRIORITY0_EN
        txn(0, 0, 0, 8'hC0, 1'b0);
        req[0] = 1'b0;
`endif
        txn(1, 0, 0, 8'hC1, 1'b0);
        req[0] = 1'b0;
        req[1] = 1'b0;
        txn(2, 0, 0, 8'hC2, 1'b1);
        req[2] = 1'b0;
        txn(3, 0, 0, 8'hC3, 1'b0);
        req[3] = 1'b0;
        repeat (6) step();

        chk("gnt_queue_empty", 32'(gnt_q.size()), 32'(0));
        chk("rsp_queue_empty", 32'(rsp_q.size()), 32'(0));
        chk("abort_count", 32'(aborts), 32'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares the single I2C master engine inside the IO-expander path among several requesters: button poll, link-power readback, port-status LED writes, and an optional host-slow-word tunnel.
- Accepts one 24-bit command per requester and grants round-robin.
- Issues the granted command to the engine with a valid/ready handshake, routes the response back to the granted requester, and aborts the engine on a response timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CLKS, 60_000, sys_clk cycles allowed from command acceptance to engine response (1 ms at 60 MHz).
- CMD_W, 24, command width: {rw[23], dev_addr[22:16], reg[15:8], wdata[7:0]}.

Ports:
- i_clk  in  1  system clock (sys_clk, 60 MHz).
- i_reset_n  in  1  asynchronous active-low reset.
- i_req  in  NUM_REQ  per-requester request level.
- i_req_cmd  in  NUM_REQ*CMD_W  packed commands; requester k occupies [k*CMD_W +: CMD_W].
- o_gnt  out  NUM_REQ  one-hot grant, held from grant until response.
- o_rsp_valid  out  NUM_REQ  one-hot single-cycle response strobe.
- o_rsp_data  out  8  read data, valid with o_rsp_valid.
- o_rsp_nack  out  1  engine reported NACK.
- o_rsp_timeout  out  1  transaction timed out.
- o_cmd_valid  out  1  command to engine valid.
- o_cmd  out  CMD_W  latched granted command.
- i_cmd_ready  in  1  engine accepts command.
- i_rsp_valid  in  1  engine response strobe.
- i_rsp_data  in  8  engine read data.
- i_rsp_nack  in  1  engine NACK flag.
- o_engine_abort  out  1  single-cycle abort to engine.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, rr_ptr = 0, timer = 0.
- IDLE:
  - If any i_req bit is set, select the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch the selected command into o_cmd, set o_gnt, go to ISSUE.
  - Grant is visible the cycle after the request is sampled (1-cycle latency).
- ISSUE:
  - o_cmd_valid = 1; o_cmd is stable.
  - On i_cmd_ready = 1: handshake; go to WAIT_RSP, timer = 0.
  - No timeout in ISSUE; the engine must eventually become ready.
- WAIT_RSP:
  - timer increments each cycle.
  - On i_rsp_valid: register i_rsp_data and i_rsp_nack; go to DONE.
  - If timer == TIMEOUT_CLKS-1 without a response: pulse o_engine_abort for one cycle, set timeout flag, go to DONE.
  - If i_rsp_valid arrives on the same cycle as the timeout: the response wins and no abort is issued.
- DONE (1 cycle):
  - o_rsp_valid[g] = 1 for the granted index g; o_rsp_data/nack/timeout driven.
  - o_rsp_data = 0 on timeout.
  - rr_ptr = (g+1) mod NUM_REQ; o_gnt cleared; go to IDLE.
  - o_rsp_* fields return to 0 the next cycle.
- Request rules:
  - A requester may drop i_req before it is granted; no grant is issued for it.
  - After grant, i_req and i_req_cmd changes are ignored until the response.
  - A requester still asserting i_req in IDLE after its response re-competes; round-robin places it last.
- i_rsp_valid is ignored outside WAIT_RSP.
- i_cmd_ready is ignored outside ISSUE.
- Timer width: $clog2(TIMEOUT_CLKS+1); the timer saturates and never wraps.
- Reset asserted mid-transaction: immediate return to IDLE, no response strobe, no abort pulse. The engine is reset by the same net.

Optional Feature:
- Macro: I2C_ARB_PRIORITY0_EN.
- Defined: requester 0 (link-power/button poll) has strict priority. In IDLE, if i_req[0] = 1 it is granted regardless of rr_ptr. rr_ptr is only updated after non-zero grants, so round-robin order among 1..NUM_REQ-1 is preserved.
- Undefined: pure round-robin over all requesters.

Test Plan:
- Single request: i_req = 4'b0100, cmd 24'h9A_12_00; ready on 3rd ISSUE cycle; rsp_data 8'h5C after 10 cycles -> o_gnt = 4'b0100 one cycle after req; o_cmd = 24'h9A1200 while valid; o_rsp_valid = 4'b0100 with data 8'h5C, nack 0, timeout 0.
- Fairness: i_req = 4'b1111 held, engine responds instantly -> grant order 0,1,2,3,0; rr_ptr wraps 3 -> 0.
- Timeout (TIMEOUT_CLKS = 16): handshake, no response -> o_engine_abort high exactly 16 cycles after handshake; o_rsp_timeout = 1, o_rsp_data = 8'h00.
- Response/timeout collision: i_rsp_valid on the timeout cycle with data 8'hA5 -> o_rsp_data = 8'hA5, timeout 0, no abort.
- Reset mid-WAIT_RSP: deassert i_reset_n -> o_gnt, o_cmd_valid, o_busy = 0 asynchronously; no o_rsp_valid pulse after release.
- I2C_ARB_PRIORITY0_EN defined: i_req = 4'b1110 with rr_ptr = 1 and req[0] rising same cycle -> requester 0 granted first, then 1,2,3.
